bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment decoders. It takes an unsigned binary value, converts it to packed BCD digits with the shift-and-add-3 (double-dabble) algorithm at one bit per clock, and holds the result stable for the per-digit 4-bit decoder inputs. A start/busy/done handshake lets counters or switch-input logic request a conversion without timing coupling to the display.

## Interface
Parameters:
- IN_W, default 8: width of the binary input. Must be at least 1.
- DIGITS, default 3: number of BCD digits produced. Must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low.
- start  in  1  request a conversion; sampled only when accepting (IDLE or DONE state).
- bin  in  IN_W  unsigned value; captured on the accepted start cycle.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  one-cycle pulse when bcd/ovf are updated.
- bcd  out  4*DIGITS  packed result; digit k occupies bits [4k+3:4k], with digit 0 as the units digit.
- ovf  out  1  high when bin > 10^DIGITS - 1. Valid with done; in that case bcd holds the low DIGITS digits.

## Operation
- FSM states:
  - IDLE: wait for start.
  - SHIFT: perform the conversion.
  - DONE: single-cycle completion state.
- Start accepted (IDLE or DONE, start=1):
  - Load the shift register with bin.
  - Clear the working BCD register and the working overflow flag.
  - Set the bit counter to IN_W.
  - Go to SHIFT.
- Each SHIFT cycle:
  - For every working digit, add 3 if the digit is ≥ 5 (4-bit result).
  - Shift the concatenation {work_bcd, shift_reg} left by 1.
  - The bit shifted out of the top of work_bcd ORs into the working overflow flag.
  - Decrement the counter.
- Leaving SHIFT: when the counter reaches 1 during a SHIFT cycle, the next state is DONE.
  - On that transition, load bcd and ovf from the post-shift working values.
- DONE:
  - done=1.
  - If start=1, accept the new request and go to SHIFT; otherwise go to IDLE.
- start while in SHIFT: ignored, not queued. bin changes during SHIFT have no effect.
- bcd/ovf are updated only on entry to DONE. They hold otherwise, including through subsequent conversions, until the next completion.
- Reset (rst_n=0 at a clock edge), including mid-conversion:
  - State returns to IDLE.
  - busy=0, done=0, bcd=0, ovf=0.
  - Working registers are cleared.
  - No done pulse is produced for the aborted conversion.

## Timing
- Accepted start at edge 0 → busy high for cycles 1..IN_W → done high in cycle IN_W+1, with bcd/ovf valid from that same cycle.
- Latency: IN_W+1 cycles from start to done.
- Back-to-back throughput: one result per IN_W+1 cycles (start held high, or reasserted during done).
- busy and done are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - BCD_DIGIT_W = 4.
  - ADJ_THRESH = 5 and ADJ_ADD = 3.
- Sub-module bcd_digit_adj: combinational 4-bit "add 3 if ≥ 5" cell, instantiated DIGITS times via generate.
- Counter width: $clog2(IN_W+1).

## Test plan
- IN_W=8, DIGITS=3, start with bin=8'd255 → done exactly 9 cycles after the start edge; bcd=12'h255, ovf=0; busy high for exactly 8 cycles.
- bin=0 → bcd=12'h000, ovf=0. Then bin=8'd9 → bcd=12'h009. Then bin=8'd100 → bcd=12'h100.
- start held high with bin=8'd37 then 8'd128 → done pulses 9 cycles apart; bcd=12'h037 then 12'h128; bcd holds 12'h037 throughout the second SHIFT.
- start pulses during SHIFT with a different bin → ignored; exactly one done; result matches the originally captured value.
- rst_n=0 on the 4th SHIFT cycle of bin=8'd200 → next cycle busy=0, done=0, bcd=0, ovf=0, state IDLE; no done follows. A new start with 8'd42 → bcd=12'h042.
- DIGITS=2, IN_W=8: bin=99 → bcd=8'h99, ovf=0. bin=100 → ovf=1, bcd=8'h00. bin=255 → ovf=1, bcd=8'h55.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Conversion controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the
  // shift so that the doubled value carries correctly into the next digit.
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // One digit of the add-3 correction.
  function automatic logic [BCD_DIGIT_W-1:0] dabble_adj(input logic [BCD_DIGIT_W-1:0] digit);
    logic [BCD_DIGIT_W-1:0] res;
    if (digit >= ADJ_THRESH) begin
      res = digit + ADJ_ADD;
    end else begin
      res = digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational "add 3 if >= 5" cell for one working BCD digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Apply the double-dabble correction to a single digit.
  always_comb begin
    digit_o = dabble_adj(digit_i);
  end

endmodule

// File: rtl/bin2bcd_seq_chk.sv
// Protocol checker for the converter handshake outputs.
module bin2bcd_seq_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic done
);

  // A conversion cannot be in progress and completing in the same cycle.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// The result registers hold the last completed conversion so the display
// decoders downstream see a stable value while the next one runs.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             state_q;
  logic [IN_W-1:0]    shift_q;
  logic [BCD_W-1:0]   work_q;
  logic               wovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_s;
  logic [IN_W-1:0]    shift_d;
  logic [BCD_W-1:0]   work_d;
  logic               wovf_d;
  logic [CNT_W-1:0]   cnt_d;

  // One correction cell per working digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next working values for one SHIFT step: shift {adjusted bcd, binary}
  // left by one; the bit leaving the top digit means the value does not fit.
  always_comb begin
    work_d  = {adj_s[BCD_W-2:0], shift_q[IN_W-1]};
    shift_d = shift_q << 1;
    wovf_d  = wovf_q | adj_s[BCD_W-1];
    cnt_d   = cnt_q - CNT_W'(1);
  end

  // Controller, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= {IN_W{1'b0}};
      work_q  <= {BCD_W{1'b0}};
      wovf_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= {BCD_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q <= bin;
            work_q  <= {BCD_W{1'b0}};
            wovf_q  <= 1'b0;
            cnt_q   <= CNT_W'(IN_W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          work_q  <= work_d;
          wovf_q  <= wovf_d;
          cnt_q   <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= work_d;
            ovf_q   <= wovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

  bin2bcd_seq_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_q),
    .done  (done_q)
  );

endmodule
